// File: rtl/mul32_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 32x32 multiplier
// and its carry-lookahead adder.
package mul32_seq_pkg;

  localparam int MUL_XLEN = 32;
  localparam int CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  // 2'd3 is unused and falls back to IDLE in the FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla32_ov.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups; also
// exposes the carry into the MSB so callers can derive signed overflow.
module cla32_ov
  import mul32_seq_pkg::*;
(
  input  logic [MUL_XLEN-1:0] a,
  input  logic [MUL_XLEN-1:0] b,
  input  logic                ci,
  output logic [MUL_XLEN-1:0] sum,
  output logic                co,
  output logic                co_prev
);

  logic [MUL_XLEN-1:0] g;
  logic [MUL_XLEN-1:0] p;
  logic [MUL_XLEN:0]   c;

  // Carries computed in a function so the group chain is not seen as a comb loop
  function automatic logic [MUL_XLEN:0] carries(input logic [MUL_XLEN-1:0] gv,
                                                input logic [MUL_XLEN-1:0] pv,
                                                input logic                cin);
    logic [MUL_XLEN:0] cv;
    cv    = '0;
    cv[0] = cin;
    for (int grp = 0; grp < MUL_XLEN / 4; grp++) begin
      cv[4*grp+1] = gv[4*grp] | (pv[4*grp] & cv[4*grp]);
      cv[4*grp+2] = gv[4*grp+1] | (pv[4*grp+1] & gv[4*grp])
                  | (pv[4*grp+1] & pv[4*grp] & cv[4*grp]);
      cv[4*grp+3] = gv[4*grp+2] | (pv[4*grp+2] & gv[4*grp+1])
                  | (pv[4*grp+2] & pv[4*grp+1] & gv[4*grp])
                  | (pv[4*grp+2] & pv[4*grp+1] & pv[4*grp] & cv[4*grp]);
      cv[4*grp+4] = gv[4*grp+3] | (pv[4*grp+3] & gv[4*grp+2])
                  | (pv[4*grp+3] & pv[4*grp+2] & gv[4*grp+1])
                  | (pv[4*grp+3] & pv[4*grp+2] & pv[4*grp+1] & gv[4*grp])
                  | (pv[4*grp+3] & pv[4*grp+2] & pv[4*grp+1] & pv[4*grp] & cv[4*grp]);
    end
    return cv;
  endfunction

  assign g       = a & b;
  assign p       = a ^ b;
  assign c       = carries(g, p, ci);
  assign sum     = p ^ c[MUL_XLEN-1:0];
  assign co      = c[MUL_XLEN];
  assign co_prev = c[MUL_XLEN-1];

endmodule

// File: rtl/mul32_seq.sv
// Sequential shift-and-add 32x32 unsigned multiplier: 32 RUN cycles, one
// DONE cycle, full 64-bit product with an upper-half-nonzero flag.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product,
  output logic              ov
);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplr;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] mplr_next;
  logic            co;
  logic            co_prev_unused;

  assign addend = mplr[0] ? mcand : '0;

  cla32_ov u_add (
    .a       (acc),
    .b       (addend),
    .ci      (1'b0),
    .sum     (sum),
    .co      (co),
    .co_prev (co_prev_unused)
  );

  // Adder carry becomes the new accumulator MSB; the bit shifted out of the
  // sum enters the top of the multiplier register, which fills with low product bits.
  assign acc_next  = {co, sum[XLEN-1:1]};
  assign mplr_next = {sum[0], mplr[XLEN-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      product <= '0;
      ov      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          acc  <= acc_next;
          mplr <= mplr_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state   <= S_DONE;
            done    <= 1'b1;
            product <= {acc_next, mplr_next};
            ov      <= |acc_next;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand width; only 32 is supported, to match the cla32_ov adder.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 32 bits: unsigned multiplicand; captured on the accepting edge.
REQ-006 The block SHALL have port b, input, 32 bits: unsigned multiplier; captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The block SHALL have port product, output, 64 bits: unsigned a*b, held until the next completion.
REQ-010 The block SHALL have port ov, output, 1 bit: high when product[63:32] != 0, updated together with product.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 IDLE SHALL go to RUN on the edge that samples start=1; on that edge mcand<=a, acc<=0, mplr<=b, cnt<=0.
REQ-013 In RUN, each edge SHALL compute {co,sum} = acc + (mplr[0] ? mcand : 0) through the adder with ci=0.
REQ-014 In RUN, each edge SHALL then shift {co,sum,mplr} right by one into {acc,mplr}, and set cnt<=cnt+1.
REQ-015 RUN SHALL last exactly 32 edges; the edge with cnt==31 SHALL move the FSM to DONE and load product<={acc_next,mplr_next} and ov.
REQ-016 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-017 done SHALL be high only while in DONE, i.e. for exactly one cycle, 32 edges after the accepting edge.
REQ-018 start SHALL be ignored in RUN and DONE, with no queuing; the earliest back-to-back accept is on the edge after DONE.
REQ-019 a and b SHALL be don't-care except on the accepting edge.
REQ-020 product and ov SHALL change only on the completion edge; intermediate acc/mplr values SHALL never appear on product.
REQ-021 The carry-out of the adder SHALL always be retained as acc bit 31 after the shift; no product bit SHALL be lost (full 64-bit result).
REQ-022 The co_prev output of the adder SHALL be left unused; ov SHALL mean unsigned 32-bit overflow of the result, not adder overflow.

Reset
REQ-023 reset_n low SHALL asynchronously force state=IDLE, cnt=0, acc=0, mplr=0, mcand=0, product=0, ov=0, done=0, busy=0.
REQ-024 Reset asserted during RUN SHALL abort the operation with no done pulse; product SHALL read 0 afterwards.
REQ-025 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-026 XLEN, the counter width (5 bits), and the FSM encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared ALU defines/package file; 2'd3 SHALL decode to IDLE.
REQ-027 The block SHALL instantiate exactly one cla32_ov as its datapath adder; no other sub-module.
REQ-028 The register, FSM and shift logic SHALL all reside in mul32_seq.

Verification
REQ-029 The bench SHALL cover: a=3, b=5, one-cycle start -> done exactly 32 cycles later; product=64'd15, ov=0; busy high for 33 cycles.
REQ-030 The bench SHALL cover: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001, ov=1.
REQ-031 The bench SHALL cover: a=32'h0, b=32'hDEADBEEF -> product=0, ov=0; then a=32'h80000000, b=2 -> product=64'h1_00000000, ov=1.
REQ-032 The bench SHALL cover: start pulsed with new operands at cycles 5 and 32 of a busy operation -> ignored; the original result is delivered, with one done pulse only.
REQ-033 The bench SHALL cover: reset_n pulsed low at RUN cycle 10 -> all outputs 0 immediately, no done; the next start=1 with a=7, b=6 -> product=42.
REQ-034 The bench SHALL cover: start held high continuously -> operations re-accepted every 34 cycles, each done pulse one cycle wide; a random 10k-vector run SHALL be checked against a 64-bit reference multiply.
